// File: rtl/spi_slave.sv
// SPI mode-0 slave. SCK/CSN/MOSI are oversampled in the clk domain; frames of
// up to 32 bits are received into rx_data, and tx_data is shifted out MSB-first.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic [5:0]  rx_nbits,
    output logic        rx_valid,
    output logic        rx_overflow,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_prev_q, csn_prev_q;
    logic                   sck_s, csn_s, mosi_s;
    logic                   sck_rise, sck_fall, csn_fall, csn_rise;

    logic [1:0]  state_q, state_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic [31:0] rx_sr_q, rx_sr_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic [5:0]  rx_nbits_q, rx_nbits_d;
    logic        rx_ovf_q, rx_ovf_d;
    logic        rx_valid_q, rx_valid_d;

    // Synchronizers idle at the bus rest levels so reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;
    assign csn_rise = csn_s & ~csn_prev_q;

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        rx_data_d  = rx_data_q;
        rx_nbits_d = rx_nbits_q;
        rx_ovf_d   = rx_ovf_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (csn_fall) begin
                    state_d = ACTIVE;
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (sck_rise) begin
                    rx_sr_d = {rx_sr_q[30:0], mosi_s};
                    if (cnt_q == 6'd32) ovf_d = 1'b1;
                    else                cnt_d = cnt_q + 6'd1;
                end
                if (sck_fall) tx_sr_d = {tx_sr_q[30:0], 1'b0};
                // Results latch from the _d values so a coincident last SCK edge counts.
                if (csn_rise) begin
                    state_d    = DONE;
                    rx_data_d  = rx_sr_d;
                    rx_nbits_d = cnt_d;
                    rx_ovf_d   = ovf_d;
                    rx_valid_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_nbits_q <= '0;
            rx_ovf_q   <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rx_data_q  <= rx_data_d;
            rx_nbits_q <= rx_nbits_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign spi_miso    = (state_q == ACTIVE) & tx_sr_q[31];
    assign busy        = (state_q == ACTIVE);
    assign rx_data     = rx_data_q;
    assign rx_nbits    = rx_nbits_q;
    assign rx_overflow = rx_ovf_q;
    assign rx_valid    = rx_valid_q;

endmodule
